// File: rtl/cache_mem_pkg.sv
// Shared constants, FSM state type and address helper for the cache memory-side responder.
package cache_mem_pkg;

  localparam int LINE_BITS = 512;
  localparam int OFFSET_W  = 6;
  localparam int ADDR_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL
  } state_t;

  // True when any address bit above the line index is set.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr, input int idx_w);
    return (addr >> (OFFSET_W + idx_w)) != '0;
  endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Refill/eviction bus between the cache (master) and the memory responder (slave).
// CACHE_MEM_RANGE_CHK_EN adds the resp_err response flag.
interface cache_mem_responder_if;
  import cache_mem_pkg::*;

  logic                 req_valid;
  logic [ADDR_W-1:0]    req_addr;
  logic                 req_ready;
  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_addr;
  logic [LINE_BITS-1:0] wb_data;
  logic                 ram_ready;
  logic [LINE_BITS-1:0] ram_data;

`ifdef CACHE_MEM_RANGE_CHK_EN
  logic                 resp_err;

  modport master (
    output req_valid, req_addr, wb_valid, wb_addr, wb_data,
    input  req_ready, ram_ready, ram_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, wb_valid, wb_addr, wb_data,
    output req_ready, ram_ready, ram_data, resp_err
  );
`else
  modport master (
    output req_valid, req_addr, wb_valid, wb_addr, wb_data,
    input  req_ready, ram_ready, ram_data
  );

  modport slave (
    input  req_valid, req_addr, wb_valid, wb_addr, wb_data,
    output req_ready, ram_ready, ram_data
  );
`endif

endinterface

// File: rtl/cache_line_store.sv
// Single-port line-granular backing store with registered read data.
// Contents start at zero and are deliberately untouched by rst; only the read register resets.
module cache_line_store #(
  parameter int IDX_W = 10,
  parameter int W     = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // rdata only moves on a read, so it doubles as the held response line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// RAM end of the cache refill/eviction path: writebacks commit before fills, fixed latencies.
// Optional CACHE_MEM_RANGE_CHK_EN flags and suppresses accesses above the indexed range.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int IDX_W  = 10,
  parameter int RD_LAT = 4,
  parameter int WB_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  cache_mem_responder_if.slave bus
);

  localparam int MAX_LAT = (RD_LAT > WB_LAT) ? RD_LAT : WB_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WB_INIT = CNT_W'(WB_LAT - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q;
  logic [IDX_W-1:0]     fill_idx_q, wb_idx_q;
  logic [LINE_BITS-1:0] wb_data_q;
  logic                 ram_ready_q;

  logic                 req_ready, acc_fill, acc_wb, cnt_zero;
  logic                 wb_commit, fill_done;
  logic                 st_we, st_re;
  logic [IDX_W-1:0]     st_addr;
  logic [LINE_BITS-1:0] st_rdata;
  logic                 unused_addr_bits;

  assign acc_fill = bus.req_valid && req_ready;
  assign acc_wb   = bus.wb_valid && req_ready;
  assign cnt_zero = (cnt_q == '0);

  // Offset bits never matter and high bits only matter under the range check.
  assign unused_addr_bits = ^{bus.req_addr, bus.wb_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (acc_wb) begin
          state_d = WB;
          cnt_d   = WB_INIT;
        end else if (acc_fill) begin
          state_d = FILL;
          cnt_d   = RD_INIT;
        end
      end
      WB: begin
        if (cnt_zero) begin
          if (pend_q) begin
            state_d = FILL;
            cnt_d   = RD_INIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FILL: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_MEM_RANGE_CHK_EN
  logic fill_oor_q, wb_oor_q, resp_err_q, ram_zero_q;
`endif

  always_comb begin
    req_ready = (state_q == IDLE);
    wb_commit = (state_q == WB) && cnt_zero;
    fill_done = (state_q == FILL) && cnt_zero;
`ifdef CACHE_MEM_RANGE_CHK_EN
    st_we     = wb_commit && !wb_oor_q;
`else
    st_we     = wb_commit;
`endif
    st_re     = fill_done;
    st_addr   = (state_q == WB) ? wb_idx_q : fill_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      ram_ready_q <= 1'b0;
`ifdef CACHE_MEM_RANGE_CHK_EN
      fill_oor_q  <= 1'b0;
      wb_oor_q    <= 1'b0;
      resp_err_q  <= 1'b0;
      ram_zero_q  <= 1'b0;
`endif
    end else begin
      ram_ready_q <= fill_done;
      if (acc_wb) pend_q <= acc_fill;
`ifdef CACHE_MEM_RANGE_CHK_EN
      if (acc_fill) fill_oor_q <= addr_out_of_range(bus.req_addr, IDX_W);
      if (acc_wb)   wb_oor_q   <= addr_out_of_range(bus.wb_addr, IDX_W);
      if (fill_done) ram_zero_q <= fill_oor_q;
      resp_err_q <= (wb_commit && wb_oor_q) || (fill_done && fill_oor_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (acc_fill) fill_idx_q <= bus.req_addr[OFFSET_W+IDX_W-1:OFFSET_W];
    if (acc_wb) begin
      wb_idx_q  <= bus.wb_addr[OFFSET_W+IDX_W-1:OFFSET_W];
      wb_data_q <= bus.wb_data;
    end
  end

  cache_line_store #(
    .IDX_W (IDX_W),
    .W     (LINE_BITS)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (st_we),
    .re    (st_re),
    .addr  (st_addr),
    .wdata (wb_data_q),
    .rdata (st_rdata)
  );

  assign bus.req_ready = req_ready;
  assign bus.ram_ready = ram_ready_q;
`ifdef CACHE_MEM_RANGE_CHK_EN
  assign bus.ram_data  = ram_zero_q ? '0 : st_rdata;
  assign bus.resp_err  = resp_err_q;
`else
  assign bus.ram_data  = st_rdata;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed vector table, reset corner cases, random traffic vs a line-store model.
module tb_cache_mem_responder;
  import cache_mem_pkg::*;

  localparam int IDX_W = 10;
  localparam int RD    = 4;
  localparam int WB    = 2;
  localparam int DEPTH = 1024;
`ifdef CACHE_MEM_RANGE_CHK_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_mem_responder_if bus();

  cache_mem_responder #(.IDX_W(IDX_W), .RD_LAT(RD), .WB_LAT(WB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [LINE_BITS-1:0] model_mem [DEPTH];

  typedef struct {
    bit                   fv;
    logic [31:0]          fa;
    bit                   wv;
    logic [31:0]          wa;
    logic [LINE_BITS-1:0] wd;
    logic [LINE_BITS-1:0] exp_d;
    string                nm;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkd(string nm, logic [LINE_BITS-1:0] act, logic [LINE_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(logic [31:0] a);
    return int'((a / 64) % DEPTH);
  endfunction

  function automatic bit oor(logic [31:0] a);
    return a >= 32'h0001_0000;
  endfunction

  // Writeback lands first, then the fill reads; out-of-range accesses are void when checked.
  function automatic logic [LINE_BITS-1:0] model_apply(bit fv, logic [31:0] fa, bit wv,
                                                       logic [31:0] wa, logic [LINE_BITS-1:0] wd);
    logic [LINE_BITS-1:0] r;
    r = '0;
    if (wv && !(RANGE && oor(wa))) model_mem[idx_of(wa)] = wd;
    if (fv && !(RANGE && oor(fa))) r = model_mem[idx_of(fa)];
    return r;
  endfunction

  function automatic logic [LINE_BITS-1:0] rnd_line();
    logic [LINE_BITS-1:0] r;
    for (int i = 0; i < LINE_BITS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15) * 64 + $urandom_range(0, 63));
    if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_0000);
    return a;
  endfunction

  function automatic vec_t mkv(bit fv, logic [31:0] fa, bit wv, logic [31:0] wa,
                               logic [LINE_BITS-1:0] wd, logic [LINE_BITS-1:0] ed, string nm);
    vec_t v;
    v.fv = fv; v.fa = fa; v.wv = wv; v.wa = wa; v.wd = wd; v.exp_d = ed; v.nm = nm;
    return v;
  endfunction

  task automatic drive(bit fv, logic [31:0] fa, bit wv, logic [31:0] wa, logic [LINE_BITS-1:0] wd);
    bus.req_valid = fv;
    bus.req_addr  = fa;
    bus.wb_valid  = wv;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
  endtask

  // Accept one transaction at edge T, then check every cycle up to one past completion
  // while throwing junk at the inputs during the busy window.
  task automatic do_txn(bit fv, logic [31:0] fa, bit wv, logic [31:0] wa,
                        logic [LINE_BITS-1:0] wd, logic [LINE_BITS-1:0] exp_d, string nm);
    int total;
    total = (wv ? WB : 0) + (fv ? RD : 0);
    chk1({nm, " req_ready before accept"}, bus.req_ready, 1'b1);
    drive(fv, fa, wv, wa, wd);
    step();
    for (int k = 1; k <= total + 1; k++) begin
      if (k <= total) drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, rnd_line());
      else            drive(1'b0, '0, 1'b0, '0, '0);
      step();
      chk1($sformatf("%s T+%0d ram_ready", nm, k), bus.ram_ready, fv && (k == total));
      chk1($sformatf("%s T+%0d req_ready", nm, k), bus.req_ready, k >= total);
      if (fv && k >= total) chkd($sformatf("%s T+%0d ram_data", nm, k), bus.ram_data, exp_d);
`ifdef CACHE_MEM_RANGE_CHK_EN
      chk1($sformatf("%s T+%0d resp_err", nm, k), bus.resp_err,
           (wv && oor(wa) && k == WB) || (fv && oor(fa) && k == total));
`endif
    end
  endtask

  logic [LINE_BITS-1:0] pat_a5, d1, d2, d3, d4, d5, d6, ed, wd;
  logic [31:0] fa, wa;
  bit fv, wv;
  int t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    drive(1'b0, '0, 1'b0, '0, '0);
    pat_a5 = {16{32'hA5A5_A5A5}};
    d1 = rnd_line(); d2 = rnd_line(); d3 = rnd_line();
    d4 = rnd_line(); d5 = rnd_line(); d6 = rnd_line();

    repeat (3) step();
    chk1("reset ram_ready", bus.ram_ready, 1'b0);
    chk1("reset req_ready", bus.req_ready, 1'b1);
    chkd("reset ram_data", bus.ram_data, '0);
`ifdef CACHE_MEM_RANGE_CHK_EN
    chk1("reset resp_err", bus.resp_err, 1'b0);
`endif
    rst = 1'b0;
    step();

    vecs.push_back(mkv(0, '0,            1, 32'h0000_0040, pat_a5, '0, "preload idx1"));
    vecs.push_back(mkv(1, 32'h0000_0040, 0, '0,            '0, pat_a5, "fill idx1"));
    vecs.push_back(mkv(0, '0,            1, 32'h0000_0080, d1, '0, "wb idx2"));
    vecs.push_back(mkv(1, 32'h0000_0080, 0, '0,            '0, d1, "fill idx2"));
    vecs.push_back(mkv(1, 32'h0000_00C0, 1, 32'h0000_00C0, d2, d2, "wb+fill idx3"));
    vecs.push_back(mkv(0, '0,            1, 32'h0000_0240, d3, '0, "wb idx9"));
    vecs.push_back(mkv(1, 32'h0000_0240, 1, 32'h0000_0140, d4, d3, "wb5 fill9"));
    vecs.push_back(mkv(1, 32'h0000_0140, 0, '0,            '0, d4, "fill idx5"));
    vecs.push_back(mkv(1, 32'h0001_0140, 0, '0,            '0, RANGE ? '0 : d4, "fill high idx5"));
    vecs.push_back(mkv(1, 32'h8000_0000, 0, '0,            '0, '0, "fill 8000_0000"));
    vecs.push_back(mkv(0, '0,            1, 32'h8000_0080, d6, '0, "wb high idx2"));
    vecs.push_back(mkv(1, 32'h0000_00BF, 0, '0,            '0, RANGE ? d1 : d6, "fill idx2 offset"));
    vecs.push_back(mkv(1, 32'h0000_3FC0, 0, '0,            '0, '0, "fill unwritten"));

    foreach (vecs[i]) begin
      void'(model_apply(vecs[i].fv, vecs[i].fa, vecs[i].wv, vecs[i].wa, vecs[i].wd));
      do_txn(vecs[i].fv, vecs[i].fa, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].exp_d, vecs[i].nm);
    end

    // Reset two cycles into a fill: no response may ever appear.
    drive(1'b1, 32'h0000_0040, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0, '0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk1("rst mid fill ram_ready", bus.ram_ready, 1'b0);
    chk1("rst mid fill req_ready", bus.req_ready, 1'b1);
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk1($sformatf("after rst fill c%0d ram_ready", k), bus.ram_ready, 1'b0);
      chk1($sformatf("after rst fill c%0d req_ready", k), bus.req_ready, 1'b1);
    end
    do_txn(1'b1, 32'h0000_0040, 1'b0, '0, '0, pat_a5, "fill idx1 after rst");

    // Reset before the writeback commits: line and pending fill are both lost.
    drive(1'b1, 32'h0000_01C0, 1'b1, 32'h0000_01C0, d5);
    step();
    drive(1'b0, '0, 1'b0, '0, '0);
    step();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk1($sformatf("after rst wb c%0d ram_ready", k), bus.ram_ready, 1'b0);
    end
    ed = model_apply(1'b1, 32'h0000_01C0, 1'b0, '0, '0);
    do_txn(1'b1, 32'h0000_01C0, 1'b0, '0, '0, ed, "fill idx7 lost wb");

    for (int n = 0; n < 40; n++) begin
      t  = $urandom_range(0, 2);
      fv = (t != 1);
      wv = (t != 0);
      fa = rnd_addr();
      wa = ($urandom_range(0, 2) == 0) ? fa : rnd_addr();
      wd = rnd_line();
      ed = model_apply(fv, fa, wv, wa, wd);
      do_txn(fv, fa, wv, wa, wd, ed, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
